cpu_int_responder: RTL and testbench

- Processor-side responder for the external interrupt controller request/ID/acknowledge handshake.
- Accepts the controller's request, checks eligibility against the core's interrupt enable, and raises a trap request with the matching vector to the pipeline.
- Once the pipeline commits the trap, returns a timed acknowledge to the controller, then re-arms.
- Sits in the core next to the exception logic, in the system clock domain.

---
 rtl/cpu_int_responder.sv | 101 ++++++++++
 tb/tb_cpu_int_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_int_responder.sv
// Processor-side responder for the external interrupt controller handshake:
// request -> trap request to the pipeline -> timed acknowledge -> re-arm.
module cpu_int_responder #(
  parameter logic [31:0] VECTOR_NORMAL = 32'h8000_0008,
  parameter logic [31:0] VECTOR_URGENT = 32'h8000_000C,
  parameter int unsigned ACK_CYCLES    = 1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 Sys_Clock,
  input  logic                 Sys_Reset,
  input  logic                 EIC_IntReq,
  input  logic                 EIC_IntId,
  output logic                 EIC_IntAck,
  input  logic                 Core_IntEnable,
  output logic                 Core_TrapReq,
  output logic [31:0]          Core_TrapVector,
  input  logic                 Core_TrapTaken,
  output logic                 Int_Busy,
  output logic [CNT_WIDTH-1:0] Int_Count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    ACK       = 2'd2,
    WAIT_DROP = 2'd3
  } stateT;

  localparam logic [3:0]           ACK_LOAD = 4'(ACK_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  stateT      state;
  logic       latchedId;
  logic [3:0] ackCnt;
  logic       eligible;
  logic       withdrawn;

  // Urgent requests bypass the core enable, both on entry and while pending.
  assign eligible  = EIC_IntReq & (EIC_IntId | Core_IntEnable);
  assign withdrawn = ~EIC_IntReq | (~latchedId & ~Core_IntEnable);

  always_ff @(posedge Sys_Clock) begin
    if (!Sys_Reset) begin
      state           <= IDLE;
      latchedId       <= 1'b0;
      ackCnt          <= 4'd0;
      EIC_IntAck      <= 1'b0;
      Core_TrapReq    <= 1'b0;
      Core_TrapVector <= 32'd0;
      Int_Busy        <= 1'b0;
      Int_Count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible) begin
            state           <= REQ;
            latchedId       <= EIC_IntId;
            Core_TrapReq    <= 1'b1;
            Core_TrapVector <= EIC_IntId ? VECTOR_URGENT : VECTOR_NORMAL;
            Int_Busy        <= 1'b1;
          end
        end
        REQ: begin
          // A commit in the same cycle as a withdrawal still gets serviced.
          if (Core_TrapTaken) begin
            state        <= ACK;
            Core_TrapReq <= 1'b0;
            EIC_IntAck   <= 1'b1;
            ackCnt       <= ACK_LOAD;
            if (Int_Count != '1) begin
              Int_Count <= Int_Count + CNT_ONE;
            end
          end else if (withdrawn) begin
            state        <= IDLE;
            Core_TrapReq <= 1'b0;
            Int_Busy     <= 1'b0;
          end
        end
        ACK: begin
          if (ackCnt == 4'd1) begin
            state      <= WAIT_DROP;
            EIC_IntAck <= 1'b0;
          end else begin
            ackCnt <= ackCnt - 4'd1;
          end
        end
        WAIT_DROP: begin
          // Holding here until the level drops stops one request being taken twice.
          if (!EIC_IntReq) begin
            state    <= IDLE;
            Int_Busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_int_responder.sv
// Scoreboard bench for cpu_int_responder: a default instance and one with a
// 4-cycle acknowledge and a 2-bit saturating counter.
module tb_cpu_int_responder;

  localparam logic [31:0] VN = 32'h8000_0008;
  localparam logic [31:0] VU = 32'h8000_000C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, reqA, idA, enA, tkA;
  logic        ackA, trapA, busyA;
  logic [31:0] vecA;
  logic [15:0] cntA;

  logic        rstB, reqB, idB, enB, tkB;
  logic        ackB, trapB, busyB;
  logic [31:0] vecB;
  logic [1:0]  cntB;

  cpu_int_responder dutA (
    .Sys_Clock      (clk),
    .Sys_Reset      (rstA),
    .EIC_IntReq     (reqA),
    .EIC_IntId      (idA),
    .EIC_IntAck     (ackA),
    .Core_IntEnable (enA),
    .Core_TrapReq   (trapA),
    .Core_TrapVector(vecA),
    .Core_TrapTaken (tkA),
    .Int_Busy       (busyA),
    .Int_Count      (cntA)
  );

  cpu_int_responder #(.ACK_CYCLES(4), .CNT_WIDTH(2)) dutB (
    .Sys_Clock      (clk),
    .Sys_Reset      (rstB),
    .EIC_IntReq     (reqB),
    .EIC_IntId      (idB),
    .EIC_IntAck     (ackB),
    .Core_IntEnable (enB),
    .Core_TrapReq   (trapB),
    .Core_TrapVector(vecB),
    .Core_TrapTaken (tkB),
    .Int_Busy       (busyB),
    .Int_Count      (cntB)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic        ack;
    logic        trap;
    logic [31:0] vec;
    logic        busy;
    int          cnt;
    string       tag;
  } expT;

  expT sb[$];
  int  cycNow = 0;
  int  total  = 0;
  int  passed = 0;

  always @(posedge clk) cycNow <= cycNow + 1;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs === expv) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  // Pop every expectation due this cycle and compare against the chosen instance.
  always @(negedge clk) begin
    expT e;
    while (sb.size() > 0 && sb[0].cyc <= cycNow) begin
      e = sb.pop_front();
      if (e.cyc != cycNow) checkValue({e.tag, "/late"}, cycNow, e.cyc);
      if (e.sel == 0) begin
        checkValue({e.tag, "/ack"},  {31'd0, ackA},  {31'd0, e.ack});
        checkValue({e.tag, "/trap"}, {31'd0, trapA}, {31'd0, e.trap});
        checkValue({e.tag, "/busy"}, {31'd0, busyA}, {31'd0, e.busy});
        checkValue({e.tag, "/cnt"},  {16'd0, cntA},  e.cnt);
        if (e.trap) checkValue({e.tag, "/vec"}, vecA, e.vec);
        $display("[%0d] A %s ack=%b trap=%b vec=%h busy=%b cnt=%0d",
                 cycNow, e.tag, ackA, trapA, vecA, busyA, cntA);
      end else begin
        checkValue({e.tag, "/ack"},  {31'd0, ackB},  {31'd0, e.ack});
        checkValue({e.tag, "/trap"}, {31'd0, trapB}, {31'd0, e.trap});
        checkValue({e.tag, "/busy"}, {31'd0, busyB}, {31'd0, e.busy});
        checkValue({e.tag, "/cnt"},  {30'd0, cntB},  e.cnt);
        if (e.trap) checkValue({e.tag, "/vec"}, vecB, e.vec);
        $display("[%0d] B %s ack=%b trap=%b vec=%h busy=%b cnt=%0d",
                 cycNow, e.tag, ackB, trapB, vecB, busyB, cntB);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input int sel, input logic req, input logic id, input logic en,
                      input logic tk, input logic eAck, input logic eTrap,
                      input logic [31:0] eVec, input logic eBusy, input int eCnt,
                      input string tag);
    expT e;
    if (sel == 0) begin
      reqA = req; idA = id; enA = en; tkA = tk;
    end else begin
      reqB = req; idB = id; enB = en; tkB = tk;
    end
    e.cyc = cycNow + 1; e.sel = sel; e.ack = eAck; e.trap = eTrap; e.vec = eVec;
    e.busy = eBusy; e.cnt = eCnt; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expCnt;
    rstA = 1'b0; reqA = 1'b0; idA = 1'b0; enA = 1'b0; tkA = 1'b0;
    rstB = 1'b0; reqB = 1'b0; idB = 1'b0; enB = 1'b0; tkB = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0,0,0,0, 0,0,32'd0,0,0, "rstA");
    step(1, 0,0,0,0, 0,0,32'd0,0,0, "rstB");
    rstA = 1'b1;

    // Normal request, taken after three cycles, level dropped later.
    for (int i = 0; i < 3; i++) step(0, 1,0,1,0, 0,1,VN,1,0, "norm_req");
    step(0, 1,0,1,1, 1,0,32'd0,1,1, "norm_tk");
    step(0, 1,0,1,0, 0,0,32'd0,1,1, "norm_ackend");
    step(0, 1,0,1,0, 0,0,32'd0,1,1, "norm_wait");
    step(0, 0,0,1,0, 0,0,32'd0,0,1, "norm_drop");
    step(0, 0,0,1,1, 0,0,32'd0,0,1, "tk_idle");

    // Masked normal request, then urgent bypasses the enable.
    for (int i = 0; i < 10; i++) step(0, 1,0,0,0, 0,0,32'd0,0,1, "masked");
    step(0, 1,1,0,0, 0,1,VU,1,1, "urgent");
    step(0, 1,1,0,1, 1,0,32'd0,1,2, "urg_tk");
    step(0, 0,1,0,0, 0,0,32'd0,1,2, "urg_ackend");
    step(0, 0,0,0,0, 0,0,32'd0,0,2, "urg_idle");

    // Withdrawal via enable, with an ID change in REQ that must be ignored.
    step(0, 1,0,1,0, 0,1,VN,1,2, "wd_req");
    step(0, 1,1,1,0, 0,1,VN,1,2, "wd_idchg");
    step(0, 1,1,0,0, 0,0,32'd0,0,2, "wd_drop");
    step(0, 0,0,1,0, 0,0,32'd0,0,2, "wd_idle");
    // Withdrawal via request level.
    step(0, 1,0,1,0, 0,1,VN,1,2, "wr_req");
    step(0, 0,0,1,0, 0,0,32'd0,0,2, "wr_drop");
    // Withdrawal coinciding with commit: commit wins.
    step(0, 1,0,1,0, 0,1,VN,1,2, "wt_req");
    step(0, 1,0,0,1, 1,0,32'd0,1,3, "wt_tk");
    step(0, 0,0,0,0, 0,0,32'd0,1,3, "wt_ackend");
    step(0, 0,0,0,0, 0,0,32'd0,0,3, "wt_idle");

    // Held request: one service only until the level drops.
    step(0, 1,0,1,0, 0,1,VN,1,3, "hold_req");
    step(0, 1,0,1,1, 1,0,32'd0,1,4, "hold_tk");
    for (int i = 0; i < 20; i++) step(0, 1,0,1,1, 0,0,32'd0,1,4, "hold_wait");
    step(0, 0,0,1,0, 0,0,32'd0,0,4, "hold_drop");
    step(0, 1,0,1,0, 0,1,VN,1,4, "hold_req2");
    step(0, 1,0,1,1, 1,0,32'd0,1,5, "hold_tk2");
    step(0, 0,0,1,0, 0,0,32'd0,1,5, "hold_ackend2");
    step(0, 0,0,1,0, 0,0,32'd0,0,5, "hold_idle2");

    // Four-cycle acknowledge and 2-bit saturating counter.
    rstB = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      expCnt = (n > 3) ? 3 : n;
      step(1, 1,0,1,0, 0,1,VN,1,(n > 4) ? 3 : n - 1, "b_req");
      step(1, 1,0,1,1, 1,0,32'd0,1,expCnt, "b_tk");
      for (int i = 0; i < 3; i++) step(1, 0,0,1,0, 1,0,32'd0,1,expCnt, "b_ack");
      step(1, 0,0,1,0, 0,0,32'd0,1,expCnt, "b_ackend");
      step(1, 0,0,1,0, 0,0,32'd0,0,expCnt, "b_idle");
    end

    // Reset asserted during the second acknowledge cycle.
    step(1, 1,0,1,0, 0,1,VN,1,3, "r_req");
    step(1, 1,0,1,1, 1,0,32'd0,1,3, "r_tk");
    step(1, 1,0,1,0, 1,0,32'd0,1,3, "r_ack2");
    rstB = 1'b0;
    step(1, 1,0,1,0, 0,0,32'd0,0,0, "r_rst");
    rstB = 1'b1;
    step(1, 0,0,1,0, 0,0,32'd0,0,0, "r_idle");

    @(posedge clk);
    #1;
    checkValue("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
